blake2_digest_reader: RTL
=========================

Name: blake2_digest_reader

Overview:
Downstream stage of the Blake2 controller path. Captures the 512-bit digest from the Blake2 core when digest_valid rises, truncates it to the configured output length, and streams it back to the processor as proc-bus-width words over a valid/ready handshake. Exports busy so the upstream controller can hold off a new hash request until readout completes.

Parameters:
DATA_W, 32, processor bus width; power of 2, 8..512, divides 512.
DIGEST_BYTES, 64, Blake2b output length nn in bytes; 1..64.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
digest  in  512  Blake2 digest; byte 0 at bits [511:504]
digest_valid  in  1  level from Blake2 core; new digest on its rising edge
flush  in  1  synchronous abort of the current readout
data_out  out  DATA_W  digest word, MSB-first
valid_out  out  1  data_out is valid
ready_in  in  1  processor accepts the word
last_out  out  1  current word is the final word
out_bytes  out  $clog2(DATA_W/8)+1  number of valid bytes in data_out, MSB-aligned
busy  out  1  readout in progress
overrun  out  1  sticky: a digest edge arrived while busy and was dropped

Behaviour:
- Reset is asynchronous on negedge reset_n. On reset: state IDLE; data_out, valid_out, last_out, busy and overrun are 0; out_bytes is 0; the internal buffer, word counter and dv_q are 0.
- Derived constants:
  - NWORDS = ceil(DIGEST_BYTES*8/DATA_W).
  - LAST_BYTES = DIGEST_BYTES - (NWORDS-1)*DATA_W/8.
- Edge detect: dv_q registers digest_valid. cap = digest_valid & ~dv_q.
- Capture: the buffer loads digest with every bit below the top DIGEST_BYTES bytes forced to 0. The word counter loads 0.
- States:
  - IDLE: on cap, capture and go to SEND. valid_out rises in the cycle after the edge cycle (latency 1). busy=1, last_out=(NWORDS==1).
  - SEND: data_out = buf[511 -: DATA_W] (registered). A handshake occurs when valid_out & ready_in.
    - Handshake, not last word: shift buf left by DATA_W, increment the counter, update last_out and out_bytes.
    - Handshake on last word: go to IDLE with valid_out=0, busy=0, last_out=0.
- While valid_out & ~ready_in: data_out, last_out and out_bytes hold stable. valid_out never drops without a handshake, except on flush.
- out_bytes = DATA_W/8 on every word except the last word, which shows LAST_BYTES. Padding bytes read as 0.
- cap while in SEND with no final handshake in that cycle: the digest is dropped and overrun is set. overrun stays set until flush or reset.
- cap in the same cycle as the final handshake: the new digest is captured, the state stays SEND and valid_out stays 1 (back-to-back, no bubble). overrun is not set.
- flush has highest priority. Next cycle: state IDLE, valid_out=0, busy=0, last_out=0, buffer and counter cleared, overrun cleared. dv_q still tracks digest_valid, so a level that stays high does not retrigger.
- cap coincident with flush is dropped.
- Reset asserted mid-readout: all outputs go to their reset values immediately. After release, a digest_valid that is already high counts as a rising edge, because dv_q starts at 0.
- Counter width: $clog2(NWORDS+1). No wrap occurs, because the counter is reset on every capture.

Decomposition:
- Shared package blake2_ctrl_pkg:
  - BLAKE2_BLOCK_W=1024, BLAKE2_DIGEST_W=512, BLAKE2_LEN_W=128.
  - State encoding localparams IDLE/SEND, shared with the controller FSM encoding style.
  - A function computing NWORDS/LAST_BYTES from DATA_W and DIGEST_BYTES.
- Single module; no sub-module is warranted, since the edge detector and shifter are a few lines.

Test Plan:
1. Defaults (32/64): rising edge on digest_valid with digest = 512'h0011…EEFF pattern, ready_in=1 → valid_out high from the cycle after the edge, 16 words, word0 = digest[511:480], last_out only on word 15, out_bytes=4 throughout, busy falls after word 15.
2. DIGEST_BYTES=30, DATA_W=32 → 8 words; word 7 carries bytes 28–29 in bits [31:16], bits [15:0]=0, out_bytes=2, last_out=1.
3. Backpressure: ready_in toggles 0/1 randomly during readout → data_out/last_out stable whenever ready_in=0, no word lost or duplicated, order preserved.
4. Overrun: second digest_valid edge at word 5 → dropped, overrun=1, remaining words come from the first digest. Then flush → overrun=0, valid_out=0 next cycle. digest_valid held high after flush → no new readout.
5. Back-to-back: new edge in the same cycle as the final handshake → valid_out stays 1, next word = second digest word 0, overrun=0.
6. Async reset asserted at word 3 with digest_valid held high → outputs 0 immediately. After release, a readout restarts from word 0 of the current digest.

Source files
------------

// File: rtl/blake2_ctrl_pkg.sv
// Shared definitions for the Blake2 controller path: core widths, readout
// state encoding and helpers that size the digest readout stream.
package blake2_ctrl_pkg;

   localparam int BLAKE2_BLOCK_W  = 1024;
   localparam int BLAKE2_DIGEST_W = 512;
   localparam int BLAKE2_LEN_W    = 128;

   localparam logic [0:0] ST_IDLE_ENC = 1'b0;
   localparam logic [0:0] ST_SEND_ENC = 1'b1;

   typedef enum logic [0:0] {
      IDLE = ST_IDLE_ENC,
      SEND = ST_SEND_ENC
   } rd_state_e;

   // Number of bus words needed to carry digest_bytes of digest.
   function automatic int digest_nwords(input int data_w, input int digest_bytes);
      return (digest_bytes * 8 + data_w - 1) / data_w;
   endfunction

   // Valid bytes carried by the final (possibly partial) word.
   function automatic int digest_last_bytes(input int data_w, input int digest_bytes);
      return digest_bytes - (digest_nwords(data_w, digest_bytes) - 1) * (data_w / 8);
   endfunction

endpackage

// File: rtl/blake2_digest_reader.sv
// Captures a Blake2 digest on the rising edge of digest_valid, truncates it to
// DIGEST_BYTES and streams it MSB-first as DATA_W words over valid/ready.
module blake2_digest_reader
   import blake2_ctrl_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int DIGEST_BYTES = 64
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [BLAKE2_DIGEST_W-1:0]    digest,
   input  logic                          digest_valid,
   input  logic                          flush,
   output logic [DATA_W-1:0]             data_out,
   output logic                          valid_out,
   input  logic                          ready_in,
   output logic                          last_out,
   output logic [$clog2(DATA_W/8):0]     out_bytes,
   output logic                          busy,
   output logic                          overrun
);

   localparam int NWORDS     = digest_nwords(DATA_W, DIGEST_BYTES);
   localparam int LAST_BYTES = digest_last_bytes(DATA_W, DIGEST_BYTES);
   localparam int CNT_W      = $clog2(NWORDS + 1);
   localparam int OB_W       = $clog2(DATA_W / 8) + 1;

   localparam logic [BLAKE2_DIGEST_W-1:0] KEEP_MASK =
      {BLAKE2_DIGEST_W{1'b1}} << (BLAKE2_DIGEST_W - 8 * DIGEST_BYTES);
   localparam logic [OB_W-1:0]  FULL_OB  = OB_W'(DATA_W / 8);
   localparam logic [OB_W-1:0]  LAST_OB  = OB_W'(LAST_BYTES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);
   localparam logic             ONE_WORD = (NWORDS == 1);

   rd_state_e                    state_q,    state_d;
   logic [BLAKE2_DIGEST_W-1:0]   buffer_q,   buffer_d;
   logic [CNT_W-1:0]             cnt_q,      cnt_d;
   logic [DATA_W-1:0]            data_q,     data_d;
   logic                         valid_q,    valid_d;
   logic                         last_q,     last_d;
   logic [OB_W-1:0]              bytes_q,    bytes_d;
   logic                         busy_q,     busy_d;
   logic                         overrun_q,  overrun_d;
   logic                         dv_q;

   logic                         cap;
   logic                         handshake;
   logic                         finalHs;
   logic                         load;
   logic [BLAKE2_DIGEST_W-1:0]   captured;
   logic [BLAKE2_DIGEST_W-1:0]   shifted;
   logic [CNT_W-1:0]             cntNext;

   assign cap       = digest_valid & ~dv_q;
   assign handshake = valid_q & ready_in;
   assign finalHs   = (state_q == SEND) & handshake & last_q;
   assign load      = cap & ~flush & ((state_q == IDLE) | finalHs);
   assign captured  = digest & KEEP_MASK;
   assign shifted   = buffer_q << DATA_W;
   assign cntNext   = cnt_q + CNT_W'(1);

   // A capture coinciding with the final handshake reloads without a bubble;
   // any other capture during SEND is dropped and flagged as overrun.
   always_comb begin
      state_d   = state_q;
      buffer_d  = buffer_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      valid_d   = valid_q;
      last_d    = last_q;
      bytes_d   = bytes_q;
      busy_d    = busy_q;
      overrun_d = overrun_q;

      if (flush) begin
         state_d   = IDLE;
         buffer_d  = '0;
         cnt_d     = '0;
         data_d    = '0;
         valid_d   = 1'b0;
         last_d    = 1'b0;
         bytes_d   = '0;
         busy_d    = 1'b0;
         overrun_d = 1'b0;
      end else if (load) begin
         state_d  = SEND;
         buffer_d = captured;
         cnt_d    = '0;
         data_d   = captured[BLAKE2_DIGEST_W-1 -: DATA_W];
         valid_d  = 1'b1;
         last_d   = ONE_WORD;
         bytes_d  = ONE_WORD ? LAST_OB : FULL_OB;
         busy_d   = 1'b1;
      end else if (finalHs) begin
         state_d  = IDLE;
         buffer_d = '0;
         data_d   = '0;
         valid_d  = 1'b0;
         last_d   = 1'b0;
         bytes_d  = '0;
         busy_d   = 1'b0;
      end else if ((state_q == SEND) && handshake) begin
         buffer_d = shifted;
         cnt_d    = cntNext;
         data_d   = shifted[BLAKE2_DIGEST_W-1 -: DATA_W];
         last_d   = (cntNext == LAST_IDX);
         bytes_d  = (cntNext == LAST_IDX) ? LAST_OB : FULL_OB;
      end

      if (!flush && (state_q == SEND) && cap && !finalHs) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         buffer_q  <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         bytes_q   <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         dv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         buffer_q  <= buffer_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         bytes_q   <= bytes_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         dv_q      <= digest_valid;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign last_out  = last_q;
   assign out_bytes = bytes_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule
